// File: rtl/moving_average_filter_gen.sv
// moving_average_filter_gen: one or two cascaded box-average stages with x aligned to y and x-y residue.
// Define MAF_SUB_SATURATE_EN to saturate sub instead of letting it wrap.
module moving_average_filter_gen #(
  parameter int DATA_W = 16,
  parameter int LOG2_WIN_MAX = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [2:0]               win_sel,
  input  logic                     cascade,
  input  logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y,
  output logic signed [DATA_W-1:0] x_delayed,
  output logic signed [DATA_W-1:0] sub,
  output logic                     valid
);
  localparam int L = LOG2_WIN_MAX;
  localparam int AW = DATA_W + L;
  logic [2:0] ws_r, k;
  logic cas_r, primed, restart;
  logic [L:0] n;
  logic [L+2:0] cnt, thr;
  logic signed [DATA_W-1:0] xr, p1, p2, p3, p4, sub_n;
  assign k = ws_r == 3'd0 ? 3'd1 : ws_r > 3'(L) ? 3'(L) : ws_r;
  assign n = (L+1)'(1) << k;
  // y becomes valid N+2 (single) or 2N+3 (cascade) samples after the restart sample
  assign thr = cas_r ? ((L+3)'(n) << 1) + (L+3)'(3) : (L+3)'(n) + (L+3)'(2);
  assign restart = !primed || win_sel != ws_r || cascade != cas_r;
`ifdef MAF_SUB_SATURATE_EN
  logic signed [DATA_W:0] diff;
  assign diff = (DATA_W+1)'(x_delayed) - (DATA_W+1)'(y);
  assign sub_n = diff[DATA_W] == diff[DATA_W-1] ? diff[DATA_W-1:0] :
                 diff[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
`else
  assign sub_n = x_delayed - y;
`endif
  genvar g;
  for (g = 0; g < 2; g++) begin : stg
    logic signed [DATA_W-1:0] mem [2**L];
    logic signed [DATA_W-1:0] din, old, m;
    logic signed [AW-1:0] acc;
    logic signed [AW:0] rnd;
    logic [L-1:0] wp;
    logic [L:0] fill;
    if (g == 0) begin : src
      assign din = xr;
    end else begin : src
      assign din = stg[0].m;
    end
    // stale memory never contributes until N post-restart samples have been written
    assign old = fill >= n ? mem[wp - n[L-1:0]] : '0;
    assign rnd = (AW+1)'(acc) + (AW+1)'(n >> 1);
    always_ff @(posedge clk)
      if (enable && !restart) mem[wp] <= din;
    always_ff @(posedge clk or negedge reset)
      if (!reset) begin
        acc <= '0;
        fill <= '0;
        wp <= '0;
        m <= '0;
      end else if (enable) begin
        acc <= restart ? '0 : acc + AW'(din) - AW'(old);
        fill <= restart ? '0 : fill + (L+1)'(fill != n);
        wp <= restart ? wp : wp + L'(1);
        m <= restart ? '0 : DATA_W'(rnd >>> k);
      end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      primed <= 1'b0;
      ws_r <= '0;
      cas_r <= 1'b0;
      xr <= '0;
      p1 <= '0;
      p2 <= '0;
      p3 <= '0;
      p4 <= '0;
      y <= '0;
      x_delayed <= '0;
      sub <= '0;
      valid <= 1'b0;
      cnt <= '0;
    end else if (enable) begin
      primed <= 1'b1;
      ws_r <= win_sel;
      cas_r <= cascade;
      xr <= x;
      p1 <= restart ? '0 : xr;
      p2 <= restart ? '0 : p1;
      p3 <= restart ? '0 : p2;
      p4 <= restart ? '0 : p3;
      y <= restart ? '0 : cas_r ? stg[1].m : stg[0].m;
      x_delayed <= restart ? '0 : cas_r ? p4 : p2;
      sub <= restart ? '0 : sub_n;
      cnt <= restart ? '0 : cnt + (L+3)'(cnt != thr);
      valid <= !restart && cnt >= thr - (L+3)'(1);
    end
endmodule

// File: tb/tb_moving_average_filter_gen.sv
// tb_moving_average_filter_gen: directed and random stimulus against a window-sum reference model.
module tb_moving_average_filter_gen;
  localparam int W = 16;
  logic clk = 1'b0, reset, enable, cascade, valid;
  logic [2:0] win_sel;
  logic signed [W-1:0] x, y, x_delayed, sub;
  int n_chk = 0, n_fail = 0;
  int hist[$];
  bit primed, pc, ev;
  int pw, mk, mn, ey, exd, esub;
  int imp_exp[8] = '{25, 50, 75, 100, 75, 50, 25, 0};

  moving_average_filter_gen #(.DATA_W(W), .LOG2_WIN_MAX(6)) dut (
    .clk(clk), .reset(reset), .enable(enable), .win_sel(win_sel), .cascade(cascade),
    .x(x), .y(y), .x_delayed(x_delayed), .sub(sub), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic int smp(input int i);
    return (i >= 1 && i <= hist.size()) ? hist[i-1] : 0;
  endfunction

  // rounded mean of the N post-restart samples ending at index i (earlier ones count as 0)
  function automatic int box1(input int i);
    int s = 0;
    for (int j = i - mn + 1; j <= i; j++) s += smp(j);
    return (s + mn / 2) >>> mk;
  endfunction

  function automatic int box2(input int i);
    int s = 0;
    for (int j = i - mn + 1; j <= i; j++) s += box1(j);
    return (s + mn / 2) >>> mk;
  endfunction

  function automatic int fix_sub(input int d);
    logic signed [W-1:0] w;
`ifdef MAF_SUB_SATURATE_EN
    w = d > 32767 ? 16'sh7fff : d < -32768 ? 16'sh8000 : W'(d);
`else
    w = W'(d);
`endif
    return int'(w);
  endfunction

  task automatic model_reset();
    primed = 0; ey = 0; exd = 0; esub = 0; ev = 0;
    hist.delete();
  endtask

  task automatic model(input int xv, input int ws, input bit cs);
    if (!primed || ws != pw || cs != pc) begin
      hist.delete();
      primed = 1; pw = ws; pc = cs;
      mk = ws == 0 ? 1 : ws > 6 ? 6 : ws;
      mn = 1 << mk;
      ey = 0; exd = 0; esub = 0; ev = 0;
      hist.push_back(xv);
    end else begin
      int t;
      esub = fix_sub(exd - ey);
      hist.push_back(xv);
      t = hist.size();
      ey = pc ? box2(t - 5) : box1(t - 3);
      exd = smp(pc ? t - 5 : t - 3);
      ev = pc ? (t - 5 >= 2 * mn - 1) : (t - 3 >= mn);
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_xd"}, x_delayed, exd);
    chk({tag, "_sub"}, sub, esub);
    chk({tag, "_valid"}, valid, ev);
  endtask

  task automatic step(input int xv, input int ws, input bit cs, input bit en, input string tag);
    x = W'(xv); win_sel = 3'(ws); cascade = cs; enable = en;
    @(posedge clk);
    #1;
    if (en) model(xv, ws, cs);
    chk_all(tag);
  endtask

  task automatic step_test();
    int py = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1000, 5, 0, 1, "step");
      if (i == 4) chk("step_first_y", y, 31);
      if (i >= 4 && i <= 35) chk("step_ramp_delta_ok", (int'(y) - py == 31 || int'(y) - py == 32) ? 1 : 0, 1);
      if (i == 34) chk("step_valid34", valid, 0);
      if (i == 35) begin
        chk("step_y35", y, 1000);
        chk("step_valid35", valid, 1);
      end
      if (i == 36) chk("step_sub36", sub, 0);
      py = y;
    end
  endtask

  function automatic int rnd_x();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    int sy, sx, ss, sv, ws, cs;
    reset = 1; enable = 0; x = 0; win_sel = 0; cascade = 0;
    model_reset();
    #1 reset = 0;
    #2 chk_all("reset");
    @(posedge clk);
    #1 reset = 1;
    step_test();
    for (int i = 0; i < 5; i++) step(777, 5, 0, 1, "pre_rst");
    #2 reset = 0;
    #1 model_reset();
    chk_all("async_rst");
    @(posedge clk);
    #1 chk_all("rst_hold");
    reset = 1;
    step_test();
    for (int i = 0; i < 8; i++) step(500, 4, 0, 1, "ramp");
    sy = y; sx = x_delayed; ss = sub; sv = valid;
    for (int i = 0; i < 10; i++) begin
      step(rnd_x(), 2, 1, 0, "hold");
      chk("hold_y_frozen", y, sy);
      chk("hold_xd_frozen", x_delayed, sx);
      chk("hold_sub_frozen", sub, ss);
      chk("hold_valid_frozen", valid, sv);
    end
    for (int i = 0; i < 20; i++) step(500, 4, 0, 1, "resume");
    for (int i = 0; i < 25; i++) step(-200, 3, 0, 1, "w3");
    chk("w3_y", y, -200);
    chk("w3_valid", valid, 1);
    step(-200, 4, 0, 1, "wchg");
    chk("wchg_valid", valid, 0);
    for (int j = 2; j <= 19; j++) begin
      step(-200, 4, 0, 1, "w4");
      if (j == 18) chk("w4_valid18", valid, 0);
      if (j == 19) begin
        chk("w4_y19", y, -200);
        chk("w4_valid19", valid, 1);
      end
    end
    for (int i = 0; i < 12; i++) step(0, 2, 1, 1, "imp_pre");
    step(400, 2, 1, 1, "imp");
    for (int j = 1; j <= 12; j++) begin
      step(0, 2, 1, 1, "imp_post");
      if (j >= 5 && j <= 12) chk("imp_seq_y", y, imp_exp[j-5]);
    end
    for (int i = 0; i < 80; i++) step(rnd_x(), 7, 0, 1, "clamp_hi");
    for (int i = 0; i < 15; i++) step(rnd_x(), 0, 0, 1, "clamp_lo");
    for (int r = 0; r < 6; r++)
      for (int j = 0; j < 8; j++) step(j < 4 ? 32767 : -32768, 2, 0, 1, "sat");
    ws = 3; cs = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) ws = $urandom_range(0, 7);
      if ($urandom_range(0, 39) == 0) cs = $urandom_range(0, 1);
      step(rnd_x(), ws, cs[0], $urandom_range(0, 4) != 0, "rand");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
